// File: rtl/fault_inject_sram_pkg.sv
// Shared definitions for the fault-injecting SRAM responder: fault-type
// codes, field widths and small decode helpers.
package fault_inject_pkg;

  localparam int TYPE_W = 3;
  localparam int FCNT_W = 8;

  localparam logic [TYPE_W-1:0] FT_NONE  = 3'd0;
  localparam logic [TYPE_W-1:0] FT_SA0   = 3'd1;
  localparam logic [TYPE_W-1:0] FT_SA1   = 3'd2;
  localparam logic [TYPE_W-1:0] FT_TF_UP = 3'd3;
  localparam logic [TYPE_W-1:0] FT_TF_DN = 3'd4;
  localparam logic [TYPE_W-1:0] FT_CF_UP = 3'd5;
  localparam logic [TYPE_W-1:0] FT_CF_DN = 3'd6;

  // Index/bit-select width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Code 7 (reserved) matches none of these and so behaves as NONE.
  function automatic logic is_sa(input logic [TYPE_W-1:0] t);
    return (t == FT_SA0) || (t == FT_SA1);
  endfunction

  function automatic logic is_cf(input logic [TYPE_W-1:0] t);
    return (t == FT_CF_UP) || (t == FT_CF_DN);
  endfunction

endpackage

// File: rtl/fault_inject_sram_if.sv
// Memory access bus plus fault-table configuration channel.
interface fault_inject_sram_if
  import fault_inject_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 2,
  parameter int N_FAULT = 4
);
  localparam int IDX_W = min1_clog2(N_FAULT);
  localparam int BIT_W = min1_clog2(DATA_W);

  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [IDX_W-1:0]  cfg_idx;
  logic [TYPE_W-1:0] cfg_type;
  logic [ADDR_W-1:0] cfg_addr;
  logic [BIT_W-1:0]  cfg_bit;
  logic [ADDR_W-1:0] cfg_aggr_addr;
  logic [BIT_W-1:0]  cfg_aggr_bit;
  logic              cfg_val;

  modport master (
    output cs, we, addr, din,
    output cfg_valid, cfg_idx, cfg_type, cfg_addr, cfg_bit,
    output cfg_aggr_addr, cfg_aggr_bit, cfg_val,
    input  dout, cfg_ready
  );

  modport slave (
    input  cs, we, addr, din,
    input  cfg_valid, cfg_idx, cfg_type, cfg_addr, cfg_bit,
    input  cfg_aggr_addr, cfg_aggr_bit, cfg_val,
    output dout, cfg_ready
  );
endinterface

// File: rtl/fault_inject_sram_fault_table.sv
// Fault table: N_FAULT entry registers, the config handshake, and per-entry
// address match against the current access address.
module fault_table
  import fault_inject_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 2,
  parameter int N_FAULT = 4,
  localparam int IDX_W  = min1_clog2(N_FAULT),
  localparam int BIT_W  = min1_clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [TYPE_W-1:0] cfg_type,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [BIT_W-1:0]  cfg_bit,
  input  logic [ADDR_W-1:0] cfg_aggr_addr,
  input  logic [BIT_W-1:0]  cfg_aggr_bit,
  input  logic              cfg_val,
  output logic [TYPE_W-1:0] ent_type  [N_FAULT],
  output logic [ADDR_W-1:0] ent_vaddr [N_FAULT],
  output logic [BIT_W-1:0]  ent_vbit  [N_FAULT],
  output logic [ADDR_W-1:0] ent_aaddr [N_FAULT],
  output logic [BIT_W-1:0]  ent_abit  [N_FAULT],
  output logic              ent_val   [N_FAULT],
  output logic [N_FAULT-1:0] vic_hit,
  output logic [N_FAULT-1:0] aggr_hit
);

  logic [TYPE_W-1:0] type_q [N_FAULT], type_d [N_FAULT];
  logic [ADDR_W-1:0] vaddr_q[N_FAULT], vaddr_d[N_FAULT];
  logic [BIT_W-1:0]  vbit_q [N_FAULT], vbit_d [N_FAULT];
  logic [ADDR_W-1:0] aaddr_q[N_FAULT], aaddr_d[N_FAULT];
  logic [BIT_W-1:0]  abit_q [N_FAULT], abit_d [N_FAULT];
  logic              val_q  [N_FAULT], val_d  [N_FAULT];
  logic              cfg_we;

  // Table updates only while no access is in flight; an index with no
  // matching entry simply writes nothing.
  always_comb begin
    cfg_ready = !cs;
    cfg_we    = cfg_valid && !cs;
    type_d    = type_q;
    vaddr_d   = vaddr_q;
    vbit_d    = vbit_q;
    aaddr_d   = aaddr_q;
    abit_d    = abit_q;
    val_d     = val_q;
    for (int i = 0; i < N_FAULT; i++) begin
      if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        type_d[i]  = cfg_type;
        vaddr_d[i] = cfg_addr;
        vbit_d[i]  = cfg_bit;
        aaddr_d[i] = cfg_aggr_addr;
        abit_d[i]  = cfg_aggr_bit;
        val_d[i]   = cfg_val;
      end
    end
  end

  // Entry registers; reset leaves every entry inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FAULT; i++) begin
        type_q[i]  <= FT_NONE;
        vaddr_q[i] <= '0;
        vbit_q[i]  <= '0;
        aaddr_q[i] <= '0;
        abit_q[i]  <= '0;
        val_q[i]   <= 1'b0;
      end
    end else begin
      type_q  <= type_d;
      vaddr_q <= vaddr_d;
      vbit_q  <= vbit_d;
      aaddr_q <= aaddr_d;
      abit_q  <= abit_d;
      val_q   <= val_d;
    end
  end

  // Per-entry victim/aggressor address match against the access address.
  always_comb begin
    vic_hit  = '0;
    aggr_hit = '0;
    for (int i = 0; i < N_FAULT; i++) begin
      vic_hit[i]  = (vaddr_q[i] == acc_addr);
      aggr_hit[i] = (aaddr_q[i] == acc_addr);
    end
  end

  assign ent_type  = type_q;
  assign ent_vaddr = vaddr_q;
  assign ent_vbit  = vbit_q;
  assign ent_aaddr = aaddr_q;
  assign ent_abit  = abit_q;
  assign ent_val   = val_q;

endmodule

// File: rtl/fault_inject_sram.sv
// Behavioural SRAM responder with a programmable fault table (stuck-at,
// transition, idempotent coupling). Read latency is one cycle.
// Optional macro FAULT_LOG_EN adds first-fault logging and a read-mismatch
// pulse checked against an internal fault-free shadow array.
module fault_inject_sram
  import fault_inject_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 2,
  parameter int N_FAULT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fault_inject_sram_if.slave bus,
  output logic               fault_act,
  output logic [FCNT_W-1:0]  fault_cnt
`ifdef FAULT_LOG_EN
  ,
  output logic               first_fault_vld,
  output logic [ADDR_W-1:0]  first_fault_addr,
  output logic               read_mismatch
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BIT_W = min1_clog2(DATA_W);

  logic [TYPE_W-1:0]  ent_type  [N_FAULT];
  logic [ADDR_W-1:0]  ent_vaddr [N_FAULT];
  logic [BIT_W-1:0]   ent_vbit  [N_FAULT];
  logic [ADDR_W-1:0]  ent_aaddr [N_FAULT];
  logic [BIT_W-1:0]   ent_abit  [N_FAULT];
  logic               ent_val   [N_FAULT];
  logic [N_FAULT-1:0] vic_hit, aggr_hit;

  logic [DATA_W-1:0] mem_q [DEPTH], mem_d [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d, rd_word;
  logic              fault_act_q, fault_act_d;
  logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic              wr, rd, wr_diff, nv, upd, old, refv, a_old, a_new;

  fault_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_FAULT(N_FAULT)) u_table (
    .clk(clk), .rst_n(rst_n), .cs(bus.cs), .acc_addr(bus.addr),
    .cfg_valid(bus.cfg_valid), .cfg_ready(bus.cfg_ready), .cfg_idx(bus.cfg_idx),
    .cfg_type(bus.cfg_type), .cfg_addr(bus.cfg_addr), .cfg_bit(bus.cfg_bit),
    .cfg_aggr_addr(bus.cfg_aggr_addr), .cfg_aggr_bit(bus.cfg_aggr_bit),
    .cfg_val(bus.cfg_val), .ent_type(ent_type), .ent_vaddr(ent_vaddr),
    .ent_vbit(ent_vbit), .ent_aaddr(ent_aaddr), .ent_abit(ent_abit),
    .ent_val(ent_val), .vic_hit(vic_hit), .aggr_hit(aggr_hit)
  );

  assign wr = bus.cs && bus.we;
  assign rd = bus.cs && !bus.we;

  // Write resolve per cell on the old array: data, then TF, then CF, then SA,
  // so later classes override earlier ones and higher entries override lower.
  always_comb begin
    mem_d   = mem_q;
    wr_diff = 1'b0;
    nv = 1'b0; upd = 1'b0; old = 1'b0; refv = 1'b0; a_old = 1'b0; a_new = 1'b0;
    if (wr) begin
      for (int w = 0; w < DEPTH; w++) begin
        for (int b = 0; b < DATA_W; b++) begin
          old  = mem_q[w][b];
          upd  = (ADDR_W'(w) == bus.addr);
          nv   = upd ? bus.din[b] : old;
          refv = nv;
          for (int i = 0; i < N_FAULT; i++) begin
            if (upd && vic_hit[i] && (ent_vbit[i] == BIT_W'(b))) begin
              if ((ent_type[i] == FT_TF_UP) && !old && nv)      nv = 1'b0;
              else if ((ent_type[i] == FT_TF_DN) && old && !nv) nv = 1'b1;
            end
          end
          for (int i = 0; i < N_FAULT; i++) begin
            if (is_cf(ent_type[i]) && aggr_hit[i] &&
                (ent_vaddr[i] == ADDR_W'(w)) && (ent_vbit[i] == BIT_W'(b)) &&
                !((ent_aaddr[i] == ent_vaddr[i]) && (ent_abit[i] == ent_vbit[i]))) begin
              a_old = mem_q[bus.addr][ent_abit[i]];
              a_new = bus.din[ent_abit[i]];
              if (((ent_type[i] == FT_CF_UP) && !a_old && a_new) ||
                  ((ent_type[i] == FT_CF_DN) && a_old && !a_new)) begin
                nv  = ent_val[i];
                upd = 1'b1;
              end
            end
          end
          for (int i = 0; i < N_FAULT; i++) begin
            if (upd && is_sa(ent_type[i]) && (ent_vaddr[i] == ADDR_W'(w)) &&
                (ent_vbit[i] == BIT_W'(b))) begin
              nv = (ent_type[i] == FT_SA1);
            end
          end
          mem_d[w][b] = nv;
          if (nv != refv) wr_diff = 1'b1;
        end
      end
    end
  end

  // Read path with stuck-at overlay, plus the fault pulse and its counter.
  always_comb begin
    rd_word = mem_q[bus.addr];
    for (int i = 0; i < N_FAULT; i++) begin
      if (is_sa(ent_type[i]) && vic_hit[i]) rd_word[ent_vbit[i]] = (ent_type[i] == FT_SA1);
    end
    dout_d      = rd ? rd_word : dout_q;
    fault_act_d = wr && wr_diff;
    fault_cnt_d = (fault_act_d && (fault_cnt_q != {FCNT_W{1'b1}})) ?
                  fault_cnt_q + 1'b1 : fault_cnt_q;
  end

  // Array, read data and fault statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
      dout_q      <= '0;
      fault_act_q <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      dout_q      <= dout_d;
      fault_act_q <= fault_act_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign bus.dout  = dout_q;
  assign fault_act = fault_act_q;
  assign fault_cnt = fault_cnt_q;

`ifdef FAULT_LOG_EN
  logic [DATA_W-1:0] shadow_q [DEPTH], shadow_d [DEPTH];
  logic              first_vld_q, first_vld_d, mism_q, mism_d;
  logic [ADDR_W-1:0] first_addr_q, first_addr_d;

  // Shadow array follows din only; the first faulty write address is kept.
  always_comb begin
    shadow_d = shadow_q;
    if (wr) shadow_d[bus.addr] = bus.din;
    mism_d       = rd && (rd_word != shadow_q[bus.addr]);
    first_vld_d  = first_vld_q || fault_act_d;
    first_addr_d = (fault_act_d && !first_vld_q) ? bus.addr : first_addr_q;
  end

  // Log and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) shadow_q[w] <= '0;
      first_vld_q  <= 1'b0;
      first_addr_q <= '0;
      mism_q       <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      first_vld_q  <= first_vld_d;
      first_addr_q <= first_addr_d;
      mism_q       <= mism_d;
    end
  end

  assign first_fault_vld  = first_vld_q;
  assign first_fault_addr = first_addr_q;
  assign read_mismatch    = mism_q;
`endif

endmodule

// File: tb/tb_fault_inject_sram.sv
// Directed self-checking bench for fault_inject_sram (FAULT_LOG_EN optional).
module tb_fault_inject_sram;
  import fault_inject_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_inject_sram_if #(.ADDR_W(4), .DATA_W(2), .N_FAULT(4)) bus ();
  logic       fault_act;
  logic [7:0] fault_cnt;
`ifdef FAULT_LOG_EN
  logic       first_fault_vld;
  logic [3:0] first_fault_addr;
  logic       read_mismatch;
`endif

  fault_inject_sram #(.ADDR_W(4), .DATA_W(2), .N_FAULT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .fault_act(fault_act), .fault_cnt(fault_cnt)
`ifdef FAULT_LOG_EN
    , .first_fault_vld(first_fault_vld), .first_fault_addr(first_fault_addr),
    .read_mismatch(read_mismatch)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [3:0] a, input logic [1:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d; bus.cfg_valid = 1'b0;
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd_word(input logic [3:0] a, output logic [1:0] d);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a; bus.cfg_valid = 1'b0;
    tick();
    d = bus.dout;
    bus.cs = 1'b0;
  endtask

  task automatic load_entry(input logic [1:0] idx, input logic [2:0] t,
                            input logic [3:0] va, input logic vb,
                            input logic [3:0] aa, input logic ab, input logic v);
    bus.cfg_valid = 1'b1; bus.cfg_idx = idx; bus.cfg_type = t;
    bus.cfg_addr = va; bus.cfg_bit = vb; bus.cfg_aggr_addr = aa;
    bus.cfg_aggr_bit = ab; bus.cfg_val = v;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.din = 0; bus.cfg_valid = 0;
    bus.cfg_idx = 0; bus.cfg_type = FT_NONE; bus.cfg_addr = 0; bus.cfg_bit = 0;
    bus.cfg_aggr_addr = 0; bus.cfg_aggr_bit = 0; bus.cfg_val = 0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.dout !== 2'b00) begin errors++; $display("[TB] FAIL reset_dout got %b want 00", bus.dout); end
    checks++; if (fault_act !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault_act got %b want 0", fault_act); end
    checks++; if (fault_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_fault_cnt got %0d want 0", fault_cnt); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cfg_ready got %b want 1", bus.cfg_ready); end
`ifdef FAULT_LOG_EN
    checks++; if (first_fault_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_first_vld got %b want 0", first_fault_vld); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_fault();
    logic [1:0] d;
    for (int a = 0; a < 16; a++) begin
      wr_word(4'(a), 2'b10);
      checks++; if (fault_act !== 1'b0) begin errors++; $display("[TB] FAIL nofault_act addr %0d got %b want 0", a, fault_act); end
    end
    for (int a = 0; a < 16; a++) begin
      rd_word(4'(a), d);
      checks++; if (d !== 2'b10) begin errors++; $display("[TB] FAIL nofault_read addr %0d got %b want 10", a, d); end
    end
    tick();
    checks++; if (bus.dout !== 2'b10) begin errors++; $display("[TB] FAIL dout_hold got %b want 10", bus.dout); end
    checks++; if (fault_cnt !== 8'd0) begin errors++; $display("[TB] FAIL nofault_cnt got %0d want 0", fault_cnt); end
  endtask

  task automatic test_stuck_at();
    logic [1:0] d;
    load_entry(2'd0, FT_SA1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    wr_word(4'd5, 2'b00);
    checks++; if (fault_act !== 1'b1) begin errors++; $display("[TB] FAIL sa_act got %b want 1", fault_act); end
    checks++; if (fault_cnt !== 8'd1) begin errors++; $display("[TB] FAIL sa_cnt got %0d want 1", fault_cnt); end
    tick();
    checks++; if (fault_act !== 1'b0) begin errors++; $display("[TB] FAIL sa_act_pulse got %b want 0", fault_act); end
    rd_word(4'd5, d);
    checks++; if (d !== 2'b01) begin errors++; $display("[TB] FAIL sa_read got %b want 01", d); end
`ifdef FAULT_LOG_EN
    checks++; if (read_mismatch !== 1'b1) begin errors++; $display("[TB] FAIL log_mismatch got %b want 1", read_mismatch); end
    checks++; if (first_fault_vld !== 1'b1) begin errors++; $display("[TB] FAIL log_first_vld got %b want 1", first_fault_vld); end
    checks++; if (first_fault_addr !== 4'd5) begin errors++; $display("[TB] FAIL log_first_addr got %0d want 5", first_fault_addr); end
`endif
  endtask

  task automatic test_transition();
    logic [1:0] d;
    load_entry(2'd1, FT_TF_UP, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    wr_word(4'd3, 2'b00);
    checks++; if (fault_act !== 1'b0) begin errors++; $display("[TB] FAIL tfup_first_act got %b want 0", fault_act); end
    wr_word(4'd3, 2'b10);
    checks++; if (fault_act !== 1'b1) begin errors++; $display("[TB] FAIL tfup_act got %b want 1", fault_act); end
    rd_word(4'd3, d);
    checks++; if (d !== 2'b00) begin errors++; $display("[TB] FAIL tfup_read got %b want 00", d); end
    load_entry(2'd1, FT_TF_DN, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    wr_word(4'd3, 2'b11);
    checks++; if (fault_act !== 1'b0) begin errors++; $display("[TB] FAIL tfdn_rise_act got %b want 0", fault_act); end
    wr_word(4'd3, 2'b01);
    rd_word(4'd3, d);
    checks++; if (d !== 2'b11) begin errors++; $display("[TB] FAIL tfdn_read got %b want 11", d); end
    checks++; if (fault_cnt !== 8'd3) begin errors++; $display("[TB] FAIL tf_cnt got %0d want 3", fault_cnt); end
  endtask

  task automatic test_coupling();
    logic [1:0] d;
    load_entry(2'd2, FT_CF_UP, 4'd9, 1'b1, 4'd2, 1'b0, 1'b1);
    wr_word(4'd9, 2'b00);
    wr_word(4'd2, 2'b01);
    checks++; if (fault_act !== 1'b1) begin errors++; $display("[TB] FAIL cf_act got %b want 1", fault_act); end
    rd_word(4'd9, d);
    checks++; if (d !== 2'b10) begin errors++; $display("[TB] FAIL cf_victim got %b want 10", d); end
    rd_word(4'd2, d);
    checks++; if (d !== 2'b01) begin errors++; $display("[TB] FAIL cf_aggr got %b want 01", d); end
    load_entry(2'd3, FT_CF_UP, 4'd7, 1'b0, 4'd7, 1'b0, 1'b0);
    wr_word(4'd7, 2'b01);
    checks++; if (fault_act !== 1'b0) begin errors++; $display("[TB] FAIL cf_self_act got %b want 0", fault_act); end
    rd_word(4'd7, d);
    checks++; if (d !== 2'b01) begin errors++; $display("[TB] FAIL cf_self_read got %b want 01", d); end
    checks++; if (fault_cnt !== 8'd4) begin errors++; $display("[TB] FAIL cf_cnt got %0d want 4", fault_cnt); end
  endtask

  task automatic test_cfg_block_and_reset();
    logic [1:0] d;
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 4'd5;
    bus.cfg_valid = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_type = FT_NONE;
    #1;
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL cfg_ready_busy got %b want 0", bus.cfg_ready); end
    tick();
    bus.cfg_valid = 1'b0; bus.cs = 1'b0;
    rd_word(4'd5, d);
    checks++; if (d !== 2'b01) begin errors++; $display("[TB] FAIL cfg_blocked got %b want 01", d); end
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 4'd5;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.dout !== 2'b00) begin errors++; $display("[TB] FAIL midreset_dout got %b want 00", bus.dout); end
    checks++; if (fault_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midreset_cnt got %0d want 0", fault_cnt); end
    bus.cs = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rd_word(4'd5, d);
    checks++; if (d !== 2'b00) begin errors++; $display("[TB] FAIL postreset_read5 got %b want 00", d); end
    rd_word(4'd9, d);
    checks++; if (d !== 2'b00) begin errors++; $display("[TB] FAIL postreset_read9 got %b want 00", d); end
`ifdef FAULT_LOG_EN
    checks++; if (first_fault_vld !== 1'b0) begin errors++; $display("[TB] FAIL postreset_first_vld got %b want 0", first_fault_vld); end
`endif
  endtask

  task automatic test_saturation();
    load_entry(2'd0, FT_SA1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int n = 0; n < 260; n++) wr_word(4'd5, 2'b00);
    checks++; if (fault_act !== 1'b1) begin errors++; $display("[TB] FAIL sat_act got %b want 1", fault_act); end
    checks++; if (fault_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_cnt got %0d want 255", fault_cnt); end
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_stuck_at();
    test_transition();
    test_coupling();
    test_cfg_block_and_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_inject_sram.md
Name: fault_inject_sram

Overview:
- Behavioural 16x2 synchronous SRAM responder for the MBIST controller, with a programmable fault table.
- Sits behind mode_mux in place of the plain memory model.
- Answers cs/we/addr/din accesses with 1-cycle read latency.
- Applies up to N_FAULT injected faults (stuck-at, transition, idempotent coupling), so BIST pass/fail detection can be exercised deterministically.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- DATA_W, 2, word width.
- N_FAULT, 4, number of fault-table entries; IDX_W = clog2(N_FAULT), minimum 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cs  in  1  chip select.
- we  in  1  write enable (1 = write, 0 = read), valid when cs=1.
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.
- cfg_valid  in  1  fault-table write request.
- cfg_ready  out  1  table can accept; = !cs.
- cfg_idx  in  IDX_W  entry index.
- cfg_type  in  3  fault type (see package).
- cfg_addr  in  ADDR_W  victim address.
- cfg_bit  in  clog2(DATA_W)  victim bit.
- cfg_aggr_addr  in  ADDR_W  aggressor address (coupling only).
- cfg_aggr_bit  in  clog2(DATA_W)  aggressor bit (coupling only).
- cfg_val  in  1  value forced on victim (coupling only).
- fault_act  out  1  1-cycle pulse: previous write's stored result was altered by a fault.
- fault_cnt  out  8  saturating count of fault_act pulses.

Behaviour:
Reset (rst_n=0, async):
- All array cells 0; every table entry type NONE; dout=0, fault_act=0, fault_cnt=0.
- Reset mid-access discards the access.

Read (cs=1, we=0):
- dout updates at the next rising edge to mem[addr], with SA entries on that cell forced; latency 1.
- dout holds its value when cs=0 or on writes.

Write (cs=1, we=1) at rising edge, evaluated on old array state, in this order:
1. new = din.
2. TF_UP on the addressed bit: old 0 and new 1 -> keep 0. TF_DN on the addressed bit: old 1 and new 0 -> keep 1.
3. CF_UP: aggressor bit rises 0->1 in this write -> victim bit = cfg_val. CF_DN: aggressor bit falls 1->0 -> victim bit = cfg_val. The victim may be in any word, including the addressed one; a coupling result overrides step-1 data on the victim.
4. SA0/SA1 force their victim bit on every stored update and on every read.

Fault-entry precedence:
- Same victim bit with multiple entries: SA beats CF beats TF; among equal class, highest index wins.
- Coupling where aggressor == victim is ignored.

fault_act:
- Asserts the cycle after a write whose final stored array differs from the fault-free result (din at addr, others unchanged).
- fault_cnt increments with it and saturates at 255.

Config:
- Entry written when cfg_valid & cfg_ready; effective from the next edge.
- cfg_ready=0 whenever cs=1, so accesses and table updates never coincide.
- Writing type NONE clears an entry.
- cfg_idx >= N_FAULT is accepted and discarded.

Addresses always lie within depth; no wrap logic.

Type encoding: 0 NONE, 1 SA0, 2 SA1, 3 TF_UP, 4 TF_DN, 5 CF_UP, 6 CF_DN, 7 reserved (treated as NONE).

Optional Feature:
- FAULT_LOG_EN defined:
  - Adds outputs first_fault_vld (1) and first_fault_addr (ADDR_W), reset 0.
  - Latched on the first fault_act pulse after reset; held until reset.
  - Also adds a 1-cycle pulse output read_mismatch: a read returned a value differing from a shadow fault-free array maintained internally.
- FAULT_LOG_EN undefined: those ports, the shadow array and the log registers are absent; all other behaviour identical.

Decomposition:
- Package fault_inject_pkg: fault-type localparams (NONE..CF_DN), entry struct/field widths, FCNT_W=8.
- One sub-module fault_table: N_FAULT entry registers, cfg handshake, and per-entry match decode (victim/aggressor hit vectors). The top keeps the array, write-resolve and read paths.

Test Plan:
1. No faults; write addr 0..15 with 2'b10, read back -> dout=2'b10 one cycle after each read; fault_act never 1; fault_cnt=0.
2. Entry0 SA1 at addr 5 bit 0; write 2'b00 to addr 5 then read -> dout=2'b01; fault_act pulses once; fault_cnt=1.
3. Entry1 TF_UP at addr 3 bit 1; write 00 then 10 to addr 3, read -> 00. Then load TF_DN on the same bit, write 11 then 01 -> 11.
4. Entry2 CF_UP aggressor addr 2 bit 0, victim addr 9 bit 1, cfg_val=1; write 00 to addr 9, then 01 to addr 2, read addr 9 -> 2'b10.
5. Assert cfg_valid while cs=1 -> cfg_ready=0 and the table is unchanged. Drop rst_n mid-read of addr 5 (SA1 loaded) -> dout=0, entry cleared, a later read of addr 5 returns 00.
6. (FAULT_LOG_EN) Scenario 2 sequence -> first_fault_vld=1, first_fault_addr=5; read_mismatch pulses on the read of addr 5.
